fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_fsm.sv | 98 +++++++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared definitions for the instruction fetch stage: FSM
//               state encoding, the NOP instruction word and the default
//               reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Fetch control states (2-bit encoding)
    typedef enum logic [1:0] {
        FS_RUN    = 2'd0,
        FS_HALT   = 2'd1,
        FS_RESUME = 2'd2
    } fetch_state_e;

    // All-zero word decodes as sll $0,$0,0, i.e. a NOP bubble
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // Default PC loaded on reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_fsm.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fsm
// Description : Control FSM of the fetch stage. Holds the RUN/HALT/RESUME
//               state register and decides, for each rising edge, whether the
//               datapath advances, takes a redirect or holds.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               go_i              - resume request (only meaningful in HALT)
//               stall_i           - hazard freeze
//               halt_req_i        - halt request from EX
//               redirect_i        - taken branch/jump from EX
//               advance_o         - datapath fetches next sequential word
//               take_redirect_o   - datapath loads redirect target
//               hold_o            - datapath registers keep their value
//               halted_o          - high while in HALT
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fsm
    import fetch_unit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic go_i,
    input  logic stall_i,
    input  logic halt_req_i,
    input  logic redirect_i,
    output logic advance_o,
    output logic take_redirect_o,
    output logic hold_o,
    output logic halted_o
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode.
    // Edge priority outside HALT: redirect > halt_req > stall > advance.
    // Reset is handled by the register and by the datapath directly, so it
    // never reaches this decode as a competing request.
    always_comb begin
        state_d         = state_q;
        advance_o       = 1'b0;
        take_redirect_o = 1'b0;
        hold_o          = 1'b1;

        case (state_q)
            FS_RUN: begin
                if (redirect_i) begin
                    take_redirect_o = 1'b1;
                    hold_o          = 1'b0;
                end else if (halt_req_i) begin
                    state_d = FS_HALT;
                end else if (!stall_i) begin
                    advance_o = 1'b1;
                    hold_o    = 1'b0;
                end
            end

            FS_HALT: begin
                // Everything except go is ignored; registers always hold
                if (go_i) begin
                    state_d = FS_RESUME;
                end
            end

            FS_RESUME: begin
                // halt_req is deliberately ignored here so the instruction
                // after the syscall gets fetched at least once.
                if (redirect_i) begin
                    take_redirect_o = 1'b1;
                    hold_o          = 1'b0;
                    state_d         = FS_RUN;
                end else if (!stall_i) begin
                    advance_o = 1'b1;
                    hold_o    = 1'b0;
                    state_d   = FS_RUN;
                end
            end

            default: begin
                state_d = FS_RUN;
            end
        endcase
    end

    assign halted_o = (state_q == FS_HALT);

endmodule : fetch_fsm
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, the IF/ID pipeline
//               register and the fetch/flush counters; sequencing comes from
//               the fetch_fsm sub-module.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               go              - resume request after a halt
//               stall           - hazard freeze of PC and IF/ID
//               halt_req        - halt request (syscall in EX)
//               redirect        - taken branch/jump resolved in EX
//               redirect_pc     - redirect target byte address
//               rom_dout        - combinational ROM data for rom_addr
//               rom_addr        - ROM word address, pc[ROM_ADDR+1:2]
//               pc              - current fetch address
//               id_ir           - IF/ID instruction register
//               id_pc_plus4     - IF/ID PC+4 register
//               id_valid        - IF/ID holds a real instruction
//               halted          - fetch FSM is in HALT
//               fetch_count     - valid instructions delivered to ID
//               flush_count     - accepted redirects
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    ROM_ADDR  = 10,
    parameter int                    DATA_BITS = 32,
    parameter logic [DATA_BITS-1:0]  RESET_PC  = DATA_BITS'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  stall,
    input  logic                  halt_req,
    input  logic                  redirect,
    input  logic [DATA_BITS-1:0]  redirect_pc,
    input  logic [DATA_BITS-1:0]  rom_dout,
    output logic [ROM_ADDR-1:0]   rom_addr,
    output logic [DATA_BITS-1:0]  pc,
    output logic [DATA_BITS-1:0]  id_ir,
    output logic [DATA_BITS-1:0]  id_pc_plus4,
    output logic                  id_valid,
    output logic                  halted,
    output logic [31:0]           fetch_count,
    output logic [31:0]           flush_count
);

    localparam logic [DATA_BITS-1:0] C_PC_STEP    = DATA_BITS'(4);
    localparam logic [DATA_BITS-1:0] C_ALIGN_MASK = ~DATA_BITS'(3);
    localparam logic [DATA_BITS-1:0] C_NOP        = DATA_BITS'(NOP_INSTR);

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic w_advance;
    logic w_take_redirect;
    logic w_hold;
    logic w_halted;

    fetch_fsm u_fsm (
        .clk             (clk),
        .rst             (rst),
        .go_i            (go),
        .stall_i         (stall),
        .halt_req_i      (halt_req),
        .redirect_i      (redirect),
        .advance_o       (w_advance),
        .take_redirect_o (w_take_redirect),
        .hold_o          (w_hold),
        .halted_o        (w_halted)
    );

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] pc_q,      pc_d;
    logic [DATA_BITS-1:0] ir_q,      ir_d;
    logic [DATA_BITS-1:0] pcp4_q,    pcp4_d;
    logic                 valid_q,   valid_d;
    logic [31:0]          fcnt_q,    fcnt_d;
    logic [31:0]          flcnt_q,   flcnt_d;

    logic [DATA_BITS-1:0] w_pc_plus4;
    logic [DATA_BITS-1:0] w_redirect_aligned;

    // Modulo-2^DATA_BITS increment; the carry out is intentionally dropped
    assign w_pc_plus4 = pc_q + C_PC_STEP;

    // Branch targets are forced to a word boundary
    assign w_redirect_aligned = redirect_pc & C_ALIGN_MASK;

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        fcnt_d  = fcnt_q;
        flcnt_d = flcnt_q;

        if (!w_hold) begin
            if (w_take_redirect) begin
                // Squash the wrong-path word already in IF/ID.
                // id_pc_plus4 is left alone: it is meaningless with
                // id_valid low.
                pc_d    = w_redirect_aligned;
                ir_d    = C_NOP;
                valid_d = 1'b0;
                flcnt_d = flcnt_q + 32'd1;
            end else if (w_advance) begin
                pc_d    = w_pc_plus4;
                ir_d    = rom_dout;
                pcp4_d  = w_pc_plus4;
                valid_d = 1'b1;
                fcnt_d  = fcnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ir_q    <= C_NOP;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
            fcnt_q  <= 32'd0;
            flcnt_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
            flcnt_q <= flcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_addr    = pc_q[ROM_ADDR+1:2];
    assign pc          = pc_q;
    assign id_ir       = ir_q;
    assign id_pc_plus4 = pcp4_q;
    assign id_valid    = valid_q;
    assign halted      = w_halted;
    assign fetch_count = fcnt_q;
    assign flush_count = flcnt_q;

endmodule : fetch_unit
`default_nettype wire
